// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter.
// State and owner encodings plus a reference NOP word.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data accesses onto one variable-latency memory port.
// One transaction in flight; fetch results cancelled by redirect are dropped.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_redirect,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_valid,
  output logic              o_if_stall,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [DATA_W/8-1:0] i_dm_be,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic [DATA_W-1:0] o_dm_rdata,
  output logic              o_dm_valid,
  output logic              o_dm_stall,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [DATA_W/8-1:0] o_mem_be,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int BE_W = DATA_W / 8;

  state_t              r_state;
  state_t              w_next;
  owner_t              r_owner;
  logic                r_discard;
  logic                r_we;
  logic [BE_W-1:0]     r_be;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;

  logic w_take_dm;
  logic w_take_if;
  logic w_mem_req;
  logic w_if_valid;
  logic w_dm_valid;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_take_dm  = 1'b0;
    w_take_if  = 1'b0;
    w_mem_req  = 1'b0;
    w_if_valid = 1'b0;
    w_dm_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_dm_req) begin
          w_take_dm = 1'b1;
          w_next    = REQ;
        end else if (i_if_req && !i_redirect) begin
          w_take_if = 1'b1;
          w_next    = REQ;
        end
      end
      REQ: begin
        w_mem_req = 1'b1;
        if (i_mem_gnt) w_next = WAIT;
      end
      WAIT: begin
        if (i_mem_rvalid) w_next = DONE;
      end
      DONE: begin
        w_dm_valid = (r_owner == OWN_DM);
        w_if_valid = (r_owner == OWN_IF) && !r_discard && !i_redirect;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_owner   <= OWN_IF;
      r_discard <= 1'b0;
      r_we      <= 1'b0;
      r_be      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else begin
      if (w_take_dm) begin
        r_owner <= OWN_DM;
        r_we    <= i_dm_we;
        r_be    <= i_dm_be;
        r_addr  <= i_dm_addr;
        r_wdata <= i_dm_wdata;
      end else if (w_take_if) begin
        r_owner <= OWN_IF;
        r_we    <= 1'b0;
        r_be    <= '1;
        r_addr  <= i_if_addr;
        r_wdata <= '0;
      end
      // Stores complete with zero data so a stale load value never leaks.
      if (r_state == WAIT && i_mem_rvalid)
        r_rdata <= r_we ? '0 : i_mem_rdata;
      if (w_next == IDLE)
        r_discard <= 1'b0;
      else if (r_state != IDLE && r_owner == OWN_IF && i_redirect)
        r_discard <= 1'b1;
    end
  end

  assign o_mem_req   = w_mem_req;
  assign o_mem_we    = r_we;
  assign o_mem_be    = r_be;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_if_rdata  = r_rdata;
  assign o_dm_rdata  = r_rdata;
  assign o_if_valid  = w_if_valid;
  assign o_dm_valid  = w_dm_valid;
  // A redirect never stalls so the PC can load the branch target.
  assign o_if_stall  = i_if_req && !w_if_valid && !i_redirect;
  assign o_dm_stall  = i_dm_req && !w_dm_valid;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency unified memory between the fetch stage (instruction reads) and the memory stage (loads/stores).
- Produces the stall signals for both stages.
- Discards fetch responses made stale by a branch/jump redirect.
- Sits between the fetch/memory pipeline stages and the external memory interface. It replaces direct combinational instruction-memory access.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_if_req  in  1  fetch stage wants the instruction at i_if_addr
i_if_addr  in  ADDR_W  fetch PC
i_redirect  in  1  branch/jump taken or flush; cancels any fetch in flight
o_if_rdata  out  DATA_W  fetched instruction, valid with o_if_valid
o_if_valid  out  1  one-cycle pulse delivering o_if_rdata
o_if_stall  out  1  hold PC and IF/ID register
i_dm_req  in  1  memory stage access request
i_dm_we  in  1  1 = store, 0 = load
i_dm_be  in  DATA_W/8  store byte enables
i_dm_addr  in  ADDR_W  data address
i_dm_wdata  in  DATA_W  store data
o_dm_rdata  out  DATA_W  load data, valid with o_dm_valid
o_dm_valid  out  1  one-cycle completion pulse (loads and stores)
o_dm_stall  out  1  hold the memory stage and upstream
o_mem_req  out  1  request to memory
o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  latched request fields
i_mem_gnt  in  1  memory accepts the request this cycle
i_mem_rvalid  in  1  response or write acknowledgement
i_mem_rdata  in  DATA_W  read data

Behaviour:
- One outstanding transaction maximum.
- FSM states: IDLE, REQ, WAIT, DONE. Registers: owner (IF/DM), discard flag, latched request fields, response data.
- Reset: state IDLE, discard 0. All o_mem_* = 0. o_if_valid = o_dm_valid = 0. Both rdata outputs = 0.
- IDLE arbitration: fixed priority, data over fetch.
  - i_dm_req: latch the DM fields, owner=DM, go to REQ.
  - Else i_if_req & ~i_redirect: latch i_if_addr with we=0 and be=all ones, owner=IF, go to REQ.
  - Else stay in IDLE.
- REQ: o_mem_req=1 and all o_mem_* held stable until i_mem_gnt. The request cannot be withdrawn. On i_mem_gnt, go to WAIT.
- WAIT: on i_mem_rvalid, capture i_mem_rdata (store: capture 0) and go to DONE.
- i_mem_rvalid in IDLE or REQ is ignored. i_mem_rvalid is never honoured in the same cycle as the i_mem_gnt that started the transaction.
- DONE (exactly one cycle, then IDLE):
  - o_dm_valid = (owner==DM).
  - o_if_valid = (owner==IF) & ~discard & ~i_redirect.
  - No arbitration happens in DONE, so requesters update their address at this edge before the next IDLE.
- Redirect: if owner==IF and the state is REQ, WAIT or DONE, i_redirect sets discard. The transaction still completes on the memory side, but no o_if_valid is produced. discard clears on entry to IDLE. Redirect has no effect on a DM transaction.
- Stalls (combinational):
  - o_if_stall = i_if_req & ~o_if_valid & ~i_redirect. Redirect never stalls, so the PC loads the target.
  - o_dm_stall = i_dm_req & ~o_dm_valid.
- Latency from request to valid with zero-wait memory (gnt in the first REQ cycle, rvalid in the first WAIT cycle): 4 cycles (IDLE→REQ→WAIT→DONE).
- A fetch pending while DM is busy waits. After DONE→IDLE, a still-asserted i_dm_req wins again. Fetch starvation is acceptable because the pipeline is stalled on the memory stage anyway.
- Reset mid-transaction: return to IDLE immediately and drop all pending state. A late i_mem_rvalid after reset is ignored.

Decomposition:
- Package mem_arb_pkg: state enum {IDLE, REQ, WAIT, DONE}, owner enum {OWN_IF, OWN_DM}, constant NOP_INSTR = 32'h00000013 for bench reference.
- Single module. No sub-module; the request-field register is inline.

Test Plan:
1. Fetch only, addr 0x0; gnt in the first REQ cycle; rvalid one cycle later with 0x00500093 -> o_mem_addr=0x0, o_if_valid pulses once with 0x00500093, o_if_stall low only in that cycle.
2. i_if_req (addr 0x4) and i_dm_req (load 0x100) rise together -> o_mem_addr=0x100 first, o_dm_valid with load data; fetch of 0x4 issues only afterwards.
3. Fetch 0x8 in WAIT, i_redirect pulsed, then rvalid -> no o_if_valid; the next request is from the new i_if_addr 0x200 and delivers its data.
4. Store: we=1, be=4'hF, addr 0x180, wdata 0xDEADBEEF -> the o_mem_* fields match, o_dm_valid pulses, o_dm_rdata=0, o_dm_stall falls with the valid.
5. i_mem_gnt held low 5 cycles in REQ -> o_mem_req and the fields stay constant for all 5 cycles, both stalls asserted for the requesters.
6. i_reset asserted in WAIT, rvalid arrives after release -> all outputs 0, no valid pulse, FSM in IDLE, next request serviced normally.
